// File: rtl/gol_sequencer_if.sv
// Host/engine signal bundle for the Game-of-Life run controller.
// The slave modport is the sequencer's view; master is the host + engine side.
interface gol_sequencer_if #(
  parameter int GRID_W = 64,
  parameter int GEN_W  = 16,
  parameter int DIV_W  = 8
);
  logic              start;
  logic [GRID_W-1:0] seed;
  logic [GEN_W-1:0]  max_gen;
  logic [DIV_W-1:0]  rate_div;
  logic              pause;
  logic              abort;
  logic              eng_load;
  logic [GRID_W-1:0] eng_seed;
  logic              eng_step;
  logic [GRID_W-1:0] eng_grid;
  logic              busy;
  logic              done;
  logic [2:0]        done_reason;
  logic [GEN_W-1:0]  gen_count;
  logic [GRID_W-1:0] grid_out;
  logic              grid_valid;

  modport slave (
    input  start, seed, max_gen, rate_div, pause, abort, eng_grid,
    output eng_load, eng_seed, eng_step, busy, done, done_reason,
           gen_count, grid_out, grid_valid
  );

  modport master (
    output start, seed, max_gen, rate_div, pause, abort, eng_grid,
    input  eng_load, eng_seed, eng_step, busy, done, done_reason,
           gen_count, grid_out, grid_valid
  );
endinterface

// File: rtl/gol_sequencer.sv
// Run controller for the 8x8 Game-of-Life engine: loads a seed, paces single
// generation steps, captures each generation and detects run termination.
module gol_sequencer #(
  parameter int GRID_W = 64,
  parameter int GEN_W  = 16,
  parameter int DIV_W  = 8
) (
  input logic            clk,
  input logic            reset,
  gol_sequencer_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_CAPTURE, S_WAIT, S_STEP, S_DONE
  } state_e;

  typedef enum logic [2:0] {
    R_NONE    = 3'd0,
    R_MAXGEN  = 3'd1,
    R_EXTINCT = 3'd2,
    R_STILL   = 3'd3,
    R_OSC2    = 3'd4,
    R_ABORT   = 3'd5
  } reason_e;

  state_e            state_q, state_d;
  reason_e           reason_q, reason_d;
  reason_e           halt_reason;
  logic [GRID_W-1:0] seed_q, seed_d;
  logic [GEN_W-1:0]  max_gen_q, max_gen_d;
  logic [DIV_W-1:0]  rate_div_q, rate_div_d;
  logic [DIV_W-1:0]  wait_cnt_q, wait_cnt_d;
  logic [GEN_W-1:0]  gen_count_q, gen_count_d;
  logic [GRID_W-1:0] prev1_q, prev1_d;
  logic [GRID_W-1:0] prev2_q, prev2_d;
  logic [GRID_W-1:0] grid_out_q, grid_out_d;
  logic              grid_valid_q, grid_valid_d;

  always_comb begin
    state_d      = state_q;
    reason_d     = reason_q;
    seed_d       = seed_q;
    max_gen_d    = max_gen_q;
    rate_div_d   = rate_div_q;
    wait_cnt_d   = wait_cnt_q;
    gen_count_d  = gen_count_q;
    prev1_d      = prev1_q;
    prev2_d      = prev2_q;
    grid_out_d   = grid_out_q;
    grid_valid_d = 1'b0;

    // Halt priority: extinction, still life, period-2, generation limit.
    halt_reason = R_NONE;
    if (bus.eng_grid == '0)
      halt_reason = R_EXTINCT;
    else if (gen_count_q != '0 && bus.eng_grid == prev1_q)
      halt_reason = R_STILL;
    else if (gen_count_q > GEN_W'(1) && bus.eng_grid == prev2_q)
      halt_reason = R_OSC2;
    else if (max_gen_q != '0 && gen_count_q == max_gen_q)
      halt_reason = R_MAXGEN;

    case (state_q)
      S_IDLE, S_DONE: begin
        if (bus.start) begin
          seed_d      = bus.seed;
          max_gen_d   = bus.max_gen;
          rate_div_d  = bus.rate_div;
          gen_count_d = '0;
          prev1_d     = '0;
          prev2_d     = '0;
          reason_d    = R_NONE;
          state_d     = S_LOAD;
        end
      end
      S_LOAD: begin
        state_d = S_CAPTURE;
        if (bus.abort) begin
          state_d  = S_DONE;
          reason_d = R_ABORT;
        end
      end
      S_CAPTURE: begin
        grid_out_d   = bus.eng_grid;
        grid_valid_d = 1'b1;
        if (bus.abort) begin
          state_d  = S_DONE;
          reason_d = R_ABORT;
        end else if (halt_reason != R_NONE) begin
          state_d  = S_DONE;
          reason_d = halt_reason;
        end else begin
          prev2_d    = prev1_q;
          prev1_d    = bus.eng_grid;
          wait_cnt_d = rate_div_q;
          state_d    = S_WAIT;
        end
      end
      S_WAIT: begin
        if (bus.abort) begin
          state_d  = S_DONE;
          reason_d = R_ABORT;
        end else if (!bus.pause) begin
          if (wait_cnt_q == '0) state_d = S_STEP;
          else                  wait_cnt_d = wait_cnt_q - 1'b1;
        end
      end
      S_STEP: begin
        if (gen_count_q != '1) gen_count_d = gen_count_q + 1'b1;
        state_d = S_CAPTURE;
        if (bus.abort) begin
          state_d  = S_DONE;
          reason_d = R_ABORT;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_IDLE;
      reason_q     <= R_NONE;
      seed_q       <= '0;
      max_gen_q    <= '0;
      rate_div_q   <= '0;
      wait_cnt_q   <= '0;
      gen_count_q  <= '0;
      prev1_q      <= '0;
      prev2_q      <= '0;
      grid_out_q   <= '0;
      grid_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      reason_q     <= reason_d;
      seed_q       <= seed_d;
      max_gen_q    <= max_gen_d;
      rate_div_q   <= rate_div_d;
      wait_cnt_q   <= wait_cnt_d;
      gen_count_q  <= gen_count_d;
      prev1_q      <= prev1_d;
      prev2_q      <= prev2_d;
      grid_out_q   <= grid_out_d;
      grid_valid_q <= grid_valid_d;
    end
  end

  assign bus.eng_load    = (state_q == S_LOAD);
  assign bus.eng_seed    = (state_q == S_LOAD) ? seed_q : '0;
  assign bus.eng_step    = (state_q == S_STEP);
  assign bus.busy        = (state_q == S_LOAD) || (state_q == S_CAPTURE) ||
                           (state_q == S_WAIT) || (state_q == S_STEP);
  assign bus.done        = (state_q == S_DONE);
  assign bus.done_reason = reason_q;
  assign bus.gen_count   = gen_count_q;
  assign bus.grid_out    = grid_out_q;
  assign bus.grid_valid  = grid_valid_q;

endmodule
